// File: rtl/keypad_conditioner.sv
// Keypad front end: two-flop synchroniser, press/release debounce,
// single-key qualification, inter-key gap and stuck-key detection.
module keypad_conditioner #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int GAP_CYCLES      = 4,
   parameter int STUCK_CYCLES    = 65535,
   parameter int CNT_W           = 16
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [9:0] k_raw,
   output logic [9:0] k_out,
   output logic       key_strobe,
   output logic [3:0] key_code,
   output logic       multi_err,
   output logic       stuck_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRESS_DB,
      S_HELD,
      S_REL_DB,
      S_GAP,
      S_STUCK
   } state_t;

   localparam logic [CNT_W-1:0] C_DB_LAST =
      CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_GAP_LAST =
      CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_STUCK_LAST =
      CNT_W'(STUCK_CYCLES - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [9:0]       r_meta;
   logic [9:0]       r_sync;
   logic [9:0]       r_cand;
   logic [9:0]       w_cand_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] r_held;
   logic [CNT_W-1:0] w_held_nxt;
   logic             r_strobe;
   logic             w_strobe_nxt;
   logic [3:0]       r_code;
   logic [3:0]       w_code_nxt;
   logic             w_any;
   logic             w_one_hot;

   function automatic logic [CNT_W-1:0] f_inc(
      input logic [CNT_W-1:0] c
   );
      return (&c) ? c : c + 1'b1;
   endfunction

   function automatic logic [3:0] f_index(input logic [9:0] v);
      logic [3:0] idx;
      idx = '0;
      for (int i = 9; i >= 0; i--) begin
         if (v[i]) idx = 4'(i);
      end
      return idx;
   endfunction

   assign w_any     = (r_sync != '0);
   assign w_one_hot = w_any && ((r_sync & (r_sync - 10'd1)) == '0);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_meta   <= '0;
         r_sync   <= '0;
         r_state  <= S_IDLE;
         r_cand   <= '0;
         r_cnt    <= '0;
         r_held   <= '0;
         r_strobe <= 1'b0;
         r_code   <= '0;
      end else begin
         r_meta   <= k_raw;
         r_sync   <= r_meta;
         r_state  <= w_state_nxt;
         r_cand   <= w_cand_nxt;
         r_cnt    <= w_cnt_nxt;
         r_held   <= w_held_nxt;
         r_strobe <= w_strobe_nxt;
         r_code   <= w_code_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_cand_nxt   = r_cand;
      w_cnt_nxt    = r_cnt;
      w_held_nxt   = r_held;
      w_strobe_nxt = 1'b0;
      w_code_nxt   = r_code;
      unique case (r_state)
         S_IDLE: begin
            if (w_one_hot) begin
               w_state_nxt = S_PRESS_DB;
               w_cand_nxt  = r_sync;
               w_cnt_nxt   = '0;
            end
         end
         S_PRESS_DB: begin
            if (r_sync != r_cand) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt == C_DB_LAST) begin
               w_state_nxt  = S_HELD;
               w_strobe_nxt = 1'b1;
               w_code_nxt   = f_index(r_cand);
               w_held_nxt   = '0;
               w_cnt_nxt    = '0;
            end else begin
               w_cnt_nxt = f_inc(r_cnt);
            end
         end
         S_HELD: begin
            if (r_sync != r_cand) begin
               w_state_nxt = S_REL_DB;
               w_cnt_nxt   = '0;
            end else if (r_held == C_STUCK_LAST) begin
               w_state_nxt = S_STUCK;
               w_cnt_nxt   = '0;
            end else begin
               w_held_nxt = f_inc(r_held);
            end
         end
         S_REL_DB: begin
            // A return to the candidate is release bounce: hold time resumes
            if (r_sync == r_cand) begin
               w_state_nxt = S_HELD;
            end else if (r_cnt == C_DB_LAST) begin
               w_state_nxt = S_GAP;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = f_inc(r_cnt);
            end
         end
         S_GAP: begin
            if (r_cnt == C_GAP_LAST) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = f_inc(r_cnt);
            end
         end
         S_STUCK: begin
            if (w_any) begin
               w_cnt_nxt = '0;
            end else if (r_cnt == C_DB_LAST) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = f_inc(r_cnt);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign k_out = (r_state == S_HELD || r_state == S_REL_DB)
                  ? r_cand : '0;
   assign key_strobe = r_strobe;
   assign key_code   = r_code;
   assign multi_err  = (r_state == S_IDLE) && w_any && !w_one_hot;
   assign stuck_err  = (r_state == S_STUCK);

endmodule

// File: tb/tb_keypad_conditioner.sv
// Directed bench for keypad_conditioner: timing tables, hand sequences
// and a per-cycle invariant monitor.
module tb_keypad_conditioner;

   localparam int DB  = 4;
   localparam int GAP = 2;
   localparam int STK = 64;

   logic       Clk;
   logic       Reset;
   logic [9:0] k_raw;
   logic [9:0] k_out;
   logic       key_strobe;
   logic [3:0] key_code;
   logic       multi_err;
   logic       stuck_err;

   int total = 0;
   int bad   = 0;
   int n_str = 0;

   keypad_conditioner #(
      .DEBOUNCE_CYCLES(DB),
      .GAP_CYCLES(GAP),
      .STUCK_CYCLES(STK),
      .CNT_W(16)
   ) dut (
      .Clk(Clk),
      .Reset(Reset),
      .k_raw(k_raw),
      .k_out(k_out),
      .key_strobe(key_strobe),
      .key_code(key_code),
      .multi_err(multi_err),
      .stuck_err(stuck_err)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)",
                  name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // invariant monitor, sampled mid-cycle
   logic [9:0] m_prev;
   logic       m_prev_str;
   int         m_zrun;
   always @(negedge Clk) begin
      if (Reset) begin
         m_prev     = '0;
         m_prev_str = 1'b0;
         m_zrun     = 1000;
      end else begin
         chk("inv_popcount", 32'($countones(k_out) <= 1), 1);
         chk("inv_no_swap",
             32'(!(k_out != 0 && m_prev != 0 && k_out != m_prev)), 1);
         chk("inv_strobe_edge",
             32'(key_strobe), 32'(k_out != 0 && m_prev == 0));
         if (key_strobe) begin
            chk("inv_strobe_consec", 32'(m_prev_str), 0);
            n_str++;
         end
         if (k_out != 0 && m_prev == 0)
            chk("inv_gap", 32'(m_zrun >= GAP), 1);
         m_zrun     = (k_out == 0) ? m_zrun + 1 : 0;
         m_prev     = k_out;
         m_prev_str = key_strobe;
      end
   end

   typedef struct {
      logic [9:0] raw;
      int         cyc;
      logic [9:0] exp_kout;
      logic [3:0] exp_code;
      int         exp_str;
   } vec_t;

   vec_t tbl[10];

   initial begin
      int s0;
      int nz;
      tbl[0] = '{10'h020, 10, 10'h020, 4'd5, 1};
      tbl[1] = '{10'h000,  8, 10'h000, 4'd5, 0};
      tbl[2] = '{10'h004, 10, 10'h004, 4'd2, 1};
      tbl[3] = '{10'h000,  8, 10'h000, 4'd2, 0};
      tbl[4] = '{10'h010, 10, 10'h010, 4'd4, 1};
      tbl[5] = '{10'h000,  8, 10'h000, 4'd4, 0};
      tbl[6] = '{10'h002, 10, 10'h002, 4'd1, 1};
      tbl[7] = '{10'h000,  8, 10'h000, 4'd1, 0};
      tbl[8] = '{10'h200, 10, 10'h200, 4'd9, 1};
      tbl[9] = '{10'h000,  8, 10'h000, 4'd9, 0};

      Reset = 1'b1;
      k_raw = '0;
      repeat (3) tick();
      chk("rst_kout", k_out, 0);
      chk("rst_strobe", key_strobe, 0);
      chk("rst_code", key_code, 0);
      chk("rst_multi", multi_err, 0);
      chk("rst_stuck", stuck_err, 0);
      Reset = 1'b0;
      repeat (2) tick();

      // single press / release latency
      s0 = n_str;
      k_raw = 10'h020;
      for (int e = 1; e <= 20; e++) begin
         tick();
         if (e == 6) chk("press_e6_kout", k_out, 0);
         if (e == 7) begin
            chk("press_e7_kout", k_out, 10'h020);
            chk("press_e7_strobe", key_strobe, 1);
            chk("press_e7_code", key_code, 5);
         end
         if (e == 8) chk("press_e8_strobe", key_strobe, 0);
      end
      k_raw = '0;
      for (int e = 1; e <= 10; e++) begin
         tick();
         if (e == 6) chk("rel_e6_kout", k_out, 10'h020);
         if (e == 7) chk("rel_e7_kout", k_out, 0);
      end
      chk("press_strobes", n_str - s0, 1);

      // reset while key 7 held
      k_raw = 10'h080;
      repeat (10) tick();
      chk("held7_kout", k_out, 10'h080);
      Reset = 1'b1;
      tick();
      chk("midrst_kout", k_out, 0);
      chk("midrst_code", key_code, 0);
      Reset = 1'b0;
      for (int e = 1; e <= 7; e++) begin
         tick();
         if (e == 6) chk("postrst_e6_kout", k_out, 0);
         if (e == 7) chk("postrst_e7_kout", k_out, 10'h080);
      end
      k_raw = '0;
      repeat (12) tick();

      // bouncing contact never accepted
      s0 = n_str;
      nz = 0;
      for (int c = 0; c < 12; c++) begin
         k_raw = ((c / 2) % 2 == 0) ? 10'h004 : 10'h000;
         tick();
         if (k_out != 0) nz++;
      end
      k_raw = '0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (k_out != 0) nz++;
      end
      chk("bounce_kout_cycles", nz, 0);
      chk("bounce_strobes", n_str - s0, 0);

      // two keys together, then one
      s0 = n_str;
      k_raw = 10'h014;
      for (int e = 1; e <= 10; e++) begin
         tick();
         if (e == 5) chk("multi_e5_err", multi_err, 1);
      end
      chk("multi_kout", k_out, 0);
      chk("multi_strobes", n_str - s0, 0);
      k_raw = 10'h004;
      for (int e = 1; e <= 7; e++) begin
         tick();
         if (e == 1) chk("multi_drop_e1_err", multi_err, 1);
         if (e == 2) chk("multi_drop_e2_err", multi_err, 0);
         if (e == 7) begin
            chk("multi_drop_kout", k_out, 10'h004);
            chk("multi_drop_code", key_code, 2);
         end
      end
      k_raw = '0;
      repeat (12) tick();

      // stuck key 3
      k_raw = 10'h008;
      for (int e = 1; e <= 80; e++) begin
         tick();
         if (e == 7)  chk("stk_e7_kout", k_out, 10'h008);
         if (e == 70) chk("stk_e70_kout", k_out, 10'h008);
         if (e == 71) begin
            chk("stk_e71_kout", k_out, 0);
            chk("stk_e71_err", stuck_err, 1);
         end
         if (e == 80) chk("stk_e80_err", stuck_err, 1);
      end
      k_raw = '0;
      for (int e = 1; e <= 8; e++) begin
         tick();
         if (e == 5) chk("stk_rel_e5_err", stuck_err, 1);
         if (e == 6) chk("stk_rel_e6_err", stuck_err, 0);
      end
      repeat (4) tick();

      // rollover: key 1 straight to key 6
      k_raw = 10'h002;
      repeat (10) tick();
      chk("roll_k1_kout", k_out, 10'h002);
      k_raw = 10'h040;
      for (int e = 1; e <= 20; e++) begin
         tick();
         if (e == 6)  chk("roll_e6_kout", k_out, 10'h002);
         if (e == 7)  chk("roll_e7_kout", k_out, 0);
         if (e == 13) chk("roll_e13_kout", k_out, 0);
         if (e == 14) begin
            chk("roll_e14_kout", k_out, 10'h040);
            chk("roll_e14_strobe", key_strobe, 1);
            chk("roll_e14_code", key_code, 6);
         end
      end
      k_raw = '0;
      repeat (12) tick();

      // key sequence 5,2,4,1,9
      for (int v = 0; v < 10; v++) begin
         s0 = n_str;
         k_raw = tbl[v].raw;
         repeat (tbl[v].cyc) tick();
         chk($sformatf("seq%0d_kout", v), k_out, tbl[v].exp_kout);
         chk($sformatf("seq%0d_code", v), key_code, tbl[v].exp_code);
         chk($sformatf("seq%0d_strobes", v), n_str - s0, tbl[v].exp_str);
      end

      repeat (2) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
